// File: rtl/net_argmax_out.sv
// Classifier output stage: tracks the best and runner-up of CLASS_NUM score beats per
// inference and reports 1-based class ids, the top score and the top-vs-second margin.
module net_argmax_out #(
  parameter int unsigned CLASS_NUM = 10,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned SIGNED    = 0,
  parameter int unsigned IDX_W     = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_conv_start,
  input  logic [DATA_W-1:0] i_score_in,
  input  logic              i_score_valid,
  input  logic              i_layer_complete,
  output logic              o_busy,
  output logic              o_result_valid,
  output logic [IDX_W-1:0]  o_class_id,
  output logic [IDX_W-1:0]  o_second_id,
  output logic [DATA_W-1:0] o_top_score,
  output logic [DATA_W:0]   o_margin,
  output logic              o_underrun,
  output logic              o_overrun
);

  localparam int unsigned CntW = $clog2(CLASS_NUM + 1);

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDone
  } state_e;

  state_e r_state, w_state_d;

  logic [CntW-1:0]   r_count;
  logic [DATA_W-1:0] r_best, r_second;
  logic [IDX_W-1:0]  r_best_idx, r_second_idx;
  logic              r_result_valid;
  logic [IDX_W-1:0]  r_class_id, r_second_id;
  logic [DATA_W-1:0] r_top_score;
  logic [DATA_W:0]   r_margin;
  logic              r_underrun, r_overrun;

  logic              w_accept, w_last;
  logic              w_underrun_set, w_overrun_set;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_best_d, w_second_d;
  logic [IDX_W-1:0]  w_best_idx_d, w_second_idx_d;
  logic [DATA_W:0]   w_best_ext, w_second_ext, w_margin;

  // Strict greater-than so that on ties the earlier (lower) index keeps its slot.
  function automatic logic f_gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  // A beat is taken only in COLLECT and never on a conv_start cycle.
  assign w_accept = (r_state == StCollect) && i_score_valid && !i_conv_start;
  assign w_last   = w_accept && (r_count == CntW'(CLASS_NUM - 1));
  assign w_idx    = IDX_W'(r_count);

  // Next best/second after folding in the current beat.
  always_comb begin
    w_best_d       = r_best;
    w_best_idx_d   = r_best_idx;
    w_second_d     = r_second;
    w_second_idx_d = r_second_idx;
    if (r_count == '0) begin
      w_best_d     = i_score_in;
      w_best_idx_d = '0;
    end else if (f_gt(i_score_in, r_best)) begin
      w_second_d     = r_best;
      w_second_idx_d = r_best_idx;
      w_best_d       = i_score_in;
      w_best_idx_d   = w_idx;
    end else if ((r_count == CntW'(1)) || f_gt(i_score_in, r_second)) begin
      // Beat 1 always lands in second when it does not beat the first.
      w_second_d     = i_score_in;
      w_second_idx_d = w_idx;
    end
  end

  // Margin is widened by one bit so best-second can never overflow.
  always_comb begin
    if (SIGNED != 0) begin
      w_best_ext   = {w_best_d[DATA_W-1], w_best_d};
      w_second_ext = {w_second_d[DATA_W-1], w_second_d};
    end else begin
      w_best_ext   = {1'b0, w_best_d};
      w_second_ext = {1'b0, w_second_d};
    end
    w_margin = w_best_ext - w_second_ext;
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  // Next-state decode and sticky flag set conditions.
  always_comb begin
    w_state_d      = r_state;
    w_underrun_set = 1'b0;
    w_overrun_set  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_conv_start) w_state_d = StCollect;
      end
      StCollect: begin
        if (i_conv_start) begin
          w_state_d = StCollect;
        end else if (w_last) begin
          // Last beat wins over a coincident layer_complete.
          w_state_d = StDone;
        end else if (i_layer_complete) begin
          w_state_d      = StIdle;
          w_underrun_set = 1'b1;
        end
      end
      StDone: begin
        if (i_conv_start) w_state_d = StCollect;
        else if (i_score_valid) w_overrun_set = 1'b1;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Datapath: frame accumulation, result capture and sticky flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count        <= '0;
      r_best         <= '0;
      r_second       <= '0;
      r_best_idx     <= '0;
      r_second_idx   <= '0;
      r_result_valid <= 1'b0;
      r_class_id     <= '0;
      r_second_id    <= '0;
      r_top_score    <= '0;
      r_margin       <= '0;
      r_underrun     <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_result_valid <= w_last;
      if (i_conv_start) begin
        r_count      <= '0;
        r_best       <= '0;
        r_second     <= '0;
        r_best_idx   <= '0;
        r_second_idx <= '0;
        r_class_id   <= '0;
        r_second_id  <= '0;
        r_margin     <= '0;
        r_underrun   <= 1'b0;
        r_overrun    <= 1'b0;
      end else begin
        if (w_accept) begin
          r_count      <= r_count + CntW'(1);
          r_best       <= w_best_d;
          r_best_idx   <= w_best_idx_d;
          r_second     <= w_second_d;
          r_second_idx <= w_second_idx_d;
        end
        if (w_last) begin
          r_class_id  <= w_best_idx_d + IDX_W'(1);
          r_second_id <= w_second_idx_d + IDX_W'(1);
          r_top_score <= w_best_d;
          r_margin    <= w_margin;
        end
        if (w_underrun_set) r_underrun <= 1'b1;
        if (w_overrun_set)  r_overrun  <= 1'b1;
      end
    end
  end

  assign o_busy         = (r_state == StCollect);
  assign o_result_valid = r_result_valid;
  assign o_class_id     = r_class_id;
  assign o_second_id    = r_second_id;
  assign o_top_score    = r_top_score;
  assign o_margin       = r_margin;
  assign o_underrun     = r_underrun;
  assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_net_argmax_out.sv
// Bench for net_argmax_out: unsigned and signed instances share one stimulus stream and
// are checked against an argmax reference computed over the whole frame.
module tb_net_argmax_out;

  localparam int N = 10;

  logic       clk = 1'b0;
  logic       rst, conv_start, score_valid, layer_complete;
  logic [7:0] score_in;

  logic       busy_u, rv_u, und_u, ovr_u, busy_s, rv_s, und_s, ovr_s;
  logic [7:0] cid_u, sid_u, top_u, cid_s, sid_s, top_s;
  logic [8:0] mar_u, mar_s;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [7:0] fr [N];

  net_argmax_out #(.CLASS_NUM(N), .DATA_W(8), .SIGNED(0), .IDX_W(8)) u_dut_u (
    .i_clk(clk), .i_rst(rst), .i_conv_start(conv_start), .i_score_in(score_in),
    .i_score_valid(score_valid), .i_layer_complete(layer_complete),
    .o_busy(busy_u), .o_result_valid(rv_u), .o_class_id(cid_u), .o_second_id(sid_u),
    .o_top_score(top_u), .o_margin(mar_u), .o_underrun(und_u), .o_overrun(ovr_u)
  );

  net_argmax_out #(.CLASS_NUM(N), .DATA_W(8), .SIGNED(1), .IDX_W(8)) u_dut_s (
    .i_clk(clk), .i_rst(rst), .i_conv_start(conv_start), .i_score_in(score_in),
    .i_score_valid(score_valid), .i_layer_complete(layer_complete),
    .o_busy(busy_s), .o_result_valid(rv_s), .o_class_id(cid_s), .o_second_id(sid_s),
    .o_top_score(top_s), .o_margin(mar_s), .o_underrun(und_s), .o_overrun(ovr_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int val(input logic [7:0] v, input bit sgn);
    if (sgn) return int'($signed(v));
    return int'({24'd0, v});
  endfunction

  // Reference: best = first index holding the maximum; second = first index holding the
  // maximum among the remaining entries.
  function automatic void model(input bit sgn, output int bi, output int si, output int mar);
    bi = 0;
    for (int i = 1; i < N; i++) if (val(fr[i], sgn) > val(fr[bi], sgn)) bi = i;
    si = -1;
    for (int i = 0; i < N; i++)
      if (i != bi && (si < 0 || val(fr[i], sgn) > val(fr[si], sgn))) si = i;
    mar = (val(fr[bi], sgn) - val(fr[si], sgn)) & 32'h1FF;
  endfunction

  // Compares all outputs of one instance; negative expectation means don't care.
  task automatic chk_out(input string tag, input bit sgn, input int e_busy, input int e_rv,
                         input int e_cid, input int e_sid, input int e_top, input int e_mar,
                         input int e_und, input int e_ovr);
    string p;
    p = sgn ? {tag, ".s"} : {tag, ".u"};
    chk({p, ".busy"}, 32'(sgn ? busy_s : busy_u), 32'(e_busy));
    chk({p, ".rv"},   32'(sgn ? rv_s : rv_u),     32'(e_rv));
    chk({p, ".cid"},  32'(sgn ? cid_s : cid_u),   32'(e_cid));
    if (e_sid >= 0) chk({p, ".sid"}, 32'(sgn ? sid_s : sid_u), 32'(e_sid));
    if (e_top >= 0) chk({p, ".top"}, 32'(sgn ? top_s : top_u), 32'(e_top));
    if (e_mar >= 0) chk({p, ".mar"}, 32'(sgn ? mar_s : mar_u), 32'(e_mar));
    chk({p, ".und"},  32'(sgn ? und_s : und_u),   32'(e_und));
    chk({p, ".ovr"},  32'(sgn ? ovr_s : ovr_u),   32'(e_ovr));
  endtask

  task automatic chk_result(input string tag, input int e_rv, input int e_ovr);
    int bi, si, mar;
    for (int s = 0; s < 2; s++) begin
      model(bit'(s), bi, si, mar);
      chk_out(tag, bit'(s), 0, e_rv, bi + 1, si + 1, int'(fr[bi]), mar, 0, e_ovr);
    end
  endtask

  // Arms the block; junk=1 presents a beat on the conv_start cycle that must be dropped.
  task automatic start(input string tag, input bit junk);
    conv_start  = 1'b1;
    score_valid = junk;
    score_in    = 8'd200;
    step();
    conv_start  = 1'b0;
    score_valid = 1'b0;
    for (int s = 0; s < 2; s++) chk_out({tag, ".arm"}, bit'(s), 1, 0, 0, 0, -1, 0, 0, 0);
  endtask

  task automatic run_frame(input string tag, input bit junk, input bit lc_last);
    start(tag, junk);
    for (int i = 0; i < N; i++) begin
      score_valid    = 1'b1;
      score_in       = fr[i];
      layer_complete = lc_last && (i == N - 1);
      step();
      if (i == N - 2) begin
        chk({tag, ".rv_early.u"}, 32'(rv_u), 32'd0);
        chk({tag, ".rv_early.s"}, 32'(rv_s), 32'd0);
      end
    end
    score_valid    = 1'b0;
    layer_complete = 1'b0;
    chk_result(tag, 1, 0);
    step();
    chk_result({tag, ".hold"}, 0, 0);
  endtask

  initial begin
    rst            = 1'b1;
    conv_start     = 1'b0;
    score_valid    = 1'b0;
    layer_complete = 1'b0;
    score_in       = 8'd0;
    #12;
    for (int s = 0; s < 2; s++) chk_out("reset", bit'(s), 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();

    // Beats in IDLE are ignored silently.
    score_valid = 1'b1;
    score_in    = 8'd77;
    step();
    score_valid = 1'b0;
    for (int s = 0; s < 2; s++) chk_out("idle_beat", bit'(s), 0, 0, 0, 0, 0, 0, 0, 0);

    // Tie on 9: lower index wins; junk beat with conv_start is dropped.
    fr = '{8'd3, 8'd9, 8'd1, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd2};
    run_frame("t1", 1'b1, 1'b0);
    chk("t1.cid_lit", 32'(cid_u), 32'd2);

    // All equal negative scores.
    for (int i = 0; i < N; i++) fr[i] = 8'hFB;
    run_frame("t2", 1'b0, 1'b0);

    // Extreme signed spread; layer_complete on the last beat still completes.
    for (int i = 0; i < N; i++) fr[i] = 8'h80;
    fr[1] = 8'h7F;
    run_frame("t3", 1'b0, 1'b1);
    chk("t3.mar_lit", 32'(mar_s), 32'd255);

    // Short frame.
    start("t4", 1'b0);
    for (int i = 0; i < 6; i++) begin
      score_valid = 1'b1;
      score_in    = 8'(i + 1);
      step();
    end
    score_valid    = 1'b0;
    layer_complete = 1'b1;
    step();
    layer_complete = 1'b0;
    for (int s = 0; s < 2; s++) chk_out("t4.short", bit'(s), 0, 0, 0, 0, -1, 0, 1, 0);
    step();
    for (int s = 0; s < 2; s++) chk_out("t4.idle", bit'(s), 0, 0, 0, 0, -1, 0, 1, 0);
    start("t4.rearm", 1'b0);

    // Overrun after a full frame, then a discarded partial frame.
    for (int i = 0; i < N; i++) fr[i] = 8'(i * 7 + 5);
    run_frame("t5", 1'b0, 1'b0);
    score_valid = 1'b1;
    score_in    = 8'd100;
    step();
    score_valid = 1'b0;
    chk_result("t5.ovr", 0, 1);
    start("t5.part", 1'b0);
    for (int i = 0; i < 4; i++) begin
      score_valid = 1'b1;
      score_in    = 8'd250;
      step();
    end
    score_valid = 1'b0;
    fr = '{8'd10, 8'd20, 8'd30, 8'd5, 8'd25, 8'd30, 8'd1, 8'd2, 8'd3, 8'd4};
    run_frame("t5.new", 1'b0, 1'b0);

    // Asynchronous reset between clock edges mid-frame.
    start("t6", 1'b0);
    for (int i = 0; i < 3; i++) begin
      score_valid = 1'b1;
      score_in    = 8'd50;
      step();
    end
    #2;
    rst = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) chk_out("t6.rst", bit'(s), 0, 0, 0, 0, 0, 0, 0, 0);
    score_valid = 1'b0;
    #1;
    rst = 1'b0;
    step();
    for (int s = 0; s < 2; s++) chk_out("t6.after", bit'(s), 0, 0, 0, 0, 0, 0, 0, 0);

    // Back-to-back random frames, some with narrow ranges to force ties.
    for (int f = 0; f < 16; f++) begin
      for (int i = 0; i < N; i++)
        fr[i] = (f % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(126, 130));
      run_frame($sformatf("rnd%0d", f), f % 3 == 0, f % 4 == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
